// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle control FSM for the 8-bit accumulator CPU
// Define CU_MEM_HANDSHAKE_EN to honour mem_ready; otherwise memory phases are single-cycle.
module cpu_control_unit #(
    parameter int OPW  = 4,
    parameter int RETW = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    input  logic            carry,
    input  logic            mem_ready,
    output logic            LoadIR,
    output logic            IncPC,
    output logic            LoadPC,
    output logic            LoadAcc,
    output logic [1:0]      AccSrc,
    output logic [2:0]      AluOp,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            AddrSel,
    output logic            halted,
    output logic [RETW-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM_RD,
        S_MEM_WR,
        S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_NOP = OPW'(4'h0);
    localparam logic [OPW-1:0] OP_LDA = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_STA = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_AND = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_OR  = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_NOT = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_LDI = OPW'(4'h9);
    localparam logic [OPW-1:0] OP_JMP = OPW'(4'hA);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(4'hB);
    localparam logic [OPW-1:0] OP_JC  = OPW'(4'hC);
    localparam logic [OPW-1:0] OP_SHL = OPW'(4'hD);
    localparam logic [OPW-1:0] OP_SHR = OPW'(4'hE);
    localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

    state_t          state_q, state_d;
    logic [RETW-1:0] retired_q, retired_d;
    logic            ready;

`ifdef CU_MEM_HANDSHAKE_EN
    assign ready = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign ready = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        LoadIR   = 1'b0;
        IncPC    = 1'b0;
        LoadPC   = 1'b0;
        LoadAcc  = 1'b0;
        AccSrc   = 2'd0;
        AluOp    = 3'b000;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        AddrSel  = 1'b0;
        halted   = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (ready) begin
                    LoadIR  = 1'b1;
                    IncPC   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP:                                      state_d = S_FETCH;
                    OP_STA:                                      state_d = S_MEM_WR;
                    OP_HLT:                                      state_d = S_HALT;
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_MEM_RD;
                    default:                                     state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_LDI: begin LoadAcc = 1'b1; AccSrc = 2'd2; end
                    OP_NOT: begin LoadAcc = 1'b1; AluOp = 3'b101; end
                    OP_SHL: begin LoadAcc = 1'b1; AluOp = 3'b110; end
                    OP_SHR: begin LoadAcc = 1'b1; AluOp = 3'b111; end
                    OP_JMP: LoadPC = 1'b1;
                    OP_JZ:  LoadPC = zero;
                    OP_JC:  LoadPC = carry;
                    default: ;
                endcase
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                AddrSel = 1'b1;
                if (ready) begin
                    LoadAcc = 1'b1;
                    state_d = S_FETCH;
                    case (opcode)
                        OP_LDA:  AccSrc = 2'd1;
                        OP_SUB:  AluOp = 3'b001;
                        OP_AND:  AluOp = 3'b010;
                        OP_OR:   AluOp = 3'b011;
                        OP_XOR:  AluOp = 3'b100;
                        default: AluOp = 3'b000;
                    endcase
                end
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                AddrSel  = 1'b1;
                if (ready) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // Strobes are forced low combinationally so a reset pulse kills them within the cycle.
        if (reset) begin
            LoadIR   = 1'b0;
            IncPC    = 1'b0;
            LoadPC   = 1'b0;
            LoadAcc  = 1'b0;
            AccSrc   = 2'd0;
            AluOp    = 3'b000;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            AddrSel  = 1'b0;
            halted   = 1'b0;
        end
    end

    always_comb begin
        retired_d = retired_q;
        if ((state_d == S_FETCH && state_q != S_FETCH) ||
            (state_d == S_HALT && state_q != S_HALT)) begin
            retired_d = retired_q + 1'b1;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - scoreboard bench for cpu_control_unit
module tb_cpu_control_unit;

`ifdef CU_MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       zero, carry, mem_ready;
    logic       LoadIR, IncPC, LoadPC, LoadAcc, MemRead, MemWrite, AddrSel, halted;
    logic [1:0] AccSrc;
    logic [2:0] AluOp;
    logic [7:0] retired;

    cpu_control_unit #(.OPW(4), .RETW(8)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .carry(carry),
        .mem_ready(mem_ready), .LoadIR(LoadIR), .IncPC(IncPC), .LoadPC(LoadPC),
        .LoadAcc(LoadAcc), .AccSrc(AccSrc), .AluOp(AluOp), .MemRead(MemRead),
        .MemWrite(MemWrite), .AddrSel(AddrSel), .halted(halted), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [21:0] v;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_ret;
    logic [3:0] cur_op;
    logic [21:0] act;

    assign act = {LoadIR, IncPC, LoadPC, LoadAcc, AccSrc, AluOp,
                  MemRead, MemWrite, AddrSel, halted, retired};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset && sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, 32'(act), 32'(e.v));
            check_eq("pc_exclusive", 32'(IncPC & LoadPC), 32'd0);
        end
    end

    function automatic logic [13:0] mk(input logic ir, input logic inc, input logic ldpc,
                                       input logic lacc, input logic [1:0] src, input logic [2:0] alu,
                                       input logic mrd, input logic mwr, input logic asel,
                                       input logic hlt);
        return {ir, inc, ldpc, lacc, src, alu, mrd, mwr, asel, hlt};
    endfunction

    task automatic step(input logic [3:0] op, input logic mr, input logic z, input logic c,
                        input logic [13:0] e, input string tag);
        exp_t it;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        carry     = c;
        it.tag = tag;
        it.v   = {e, exp_ret};
        sb.push_back(it);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clock);
        #1;
        reset     = 1'b1;
        mem_ready = 1'b0;
        exp_ret   = 8'd0;
        cur_op    = 4'h0;
        repeat (cycles) begin
            @(negedge clock);
            check_eq("reset_outputs", 32'(act), 32'd0);
        end
    endtask

    task automatic do_fetch(input logic [3:0] op, input int fw, input logic z, input logic c);
        int nw;
        nw = HS ? fw : 0;
        for (int i = 0; i < nw; i++)
            step(cur_op, 1'b0, z, c, mk(0,0,0,0,2'd0,3'd0,1,0,0,0), "fetch_wait");
        step(cur_op, HS, z, c, mk(1,1,0,0,2'd0,3'd0,1,0,0,0), "fetch");
        cur_op = op;
    endtask

    task automatic do_decode(input logic z, input logic c);
        step(cur_op, 1'($urandom_range(0, 1)), z, c, 14'd0, "decode");
    endtask

    task automatic run(input logic [3:0] op, input logic z, input logic c, input int fw, input int mw);
        int         nw;
        logic [2:0] alu;
        nw = HS ? mw : 0;
        do_fetch(op, fw, z, c);
        do_decode(z, c);
        case (op)
            4'h0: ;
            4'hF: begin
                exp_ret++;
                step(op, 1'b1, z, c, mk(0,0,0,0,2'd0,3'd0,0,0,0,1), "halt");
                step(op, 1'b0, z, c, mk(0,0,0,0,2'd0,3'd0,0,0,0,1), "halt_hold");
            end
            4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                case (op)
                    4'h4:    alu = 3'b001;
                    4'h5:    alu = 3'b010;
                    4'h6:    alu = 3'b011;
                    4'h7:    alu = 3'b100;
                    default: alu = 3'b000;
                endcase
                for (int i = 0; i < nw; i++)
                    step(op, 1'b0, z, c, mk(0,0,0,0,2'd0,3'd0,1,0,1,0), "memrd_wait");
                step(op, HS, z, c, mk(0,0,0,1,(op == 4'h1) ? 2'd1 : 2'd0,alu,1,0,1,0), "memrd");
            end
            4'h2: begin
                for (int i = 0; i < nw; i++)
                    step(op, 1'b0, z, c, mk(0,0,0,0,2'd0,3'd0,0,1,1,0), "memwr_wait");
                step(op, HS, z, c, mk(0,0,0,0,2'd0,3'd0,0,1,1,0), "memwr");
            end
            4'h9: step(op, 1'b0, z, c, mk(0,0,0,1,2'd2,3'b000,0,0,0,0), "exec_ldi");
            4'h8: step(op, 1'b0, z, c, mk(0,0,0,1,2'd0,3'b101,0,0,0,0), "exec_not");
            4'hD: step(op, 1'b0, z, c, mk(0,0,0,1,2'd0,3'b110,0,0,0,0), "exec_shl");
            4'hE: step(op, 1'b0, z, c, mk(0,0,0,1,2'd0,3'b111,0,0,0,0), "exec_shr");
            4'hA: step(op, 1'b1, z, c, mk(0,0,1,0,2'd0,3'd0,0,0,0,0), "exec_jmp");
            4'hB: step(op, 1'b0, z, c, mk(0,0,z,0,2'd0,3'd0,0,0,0,0), "exec_jz");
            default: step(op, 1'b1, z, c, mk(0,0,c,0,2'd0,3'd0,0,0,0,0), "exec_jc");
        endcase
        if (op != 4'hF) exp_ret++;
    endtask

    initial begin
        reset = 1'b1; opcode = 4'h0; zero = 1'b0; carry = 1'b0; mem_ready = 1'b0;
        exp_ret = 8'd0; cur_op = 4'h0;
        do_reset(3);

        run(4'h9, 0, 0, 0, 0);
        run(4'h3, 0, 0, 0, 0);
        run(4'h2, 0, 0, 0, 0);
        run(4'hF, 0, 0, 0, 0);

        do_reset(1);
        run(4'hB, 1, 0, 0, 0);
        run(4'hB, 0, 1, 0, 0);
        run(4'hC, 0, 1, 0, 0);
        run(4'hC, 1, 0, 0, 0);
        run(4'hA, 0, 0, 0, 0);
        run(4'h8, 0, 0, 0, 0);
        run(4'hD, 0, 0, 0, 0);
        run(4'hE, 0, 0, 0, 0);
        run(4'h0, 0, 0, 0, 0);
        run(4'h1, 0, 0, 0, 0);
        run(4'h4, 0, 0, 0, 0);
        run(4'h5, 0, 0, 0, 0);
        run(4'h6, 0, 0, 0, 0);
        run(4'h7, 0, 0, 0, 0);
        run(4'h1, 0, 0, 3, 2);
        run(4'h2, 0, 0, 1, 2);
        run(4'h3, 1, 1, 0, 1);

        do_fetch(4'h2, 0, 0, 0);
        do_decode(0, 0);
        step(4'h2, 1'b0, 0, 0, mk(0,0,0,0,2'd0,3'd0,0,1,1,0), "memwr_pre_reset");
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("reset_pulse_outputs", 32'(act), 32'd0);
        exp_ret = 8'd0;
        cur_op  = 4'h0;
        if (HS) begin
            #1;
            reset = 1'b0;
        end
        run(4'h9, 0, 0, 0, 0);

        do_reset(1);
        repeat (256) run(4'h0, 0, 0, 0, 0);
        run(4'hF, 0, 0, 0, 0);

        @(negedge clock);
        #1;
        check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle control FSM for the 8-bit accumulator CPU. It sequences the instruction register, program counter, accumulator/ALU and memory port through fetch, decode, execute and memory phases. It takes the 4-bit opcode from the instruction register and the datapath flags, and drives every load/select strobe, including `LoadIR`.

## Interface
- `OPW`, 4: opcode width; fixed at 4 for the current ISA.
- `RETW`, 8: width of the retired-instruction counter.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  OPW  `IR[3:0]`; stable from DECODE until the next `LoadIR`.
- `zero`  in  1  registered accumulator-zero flag from the datapath.
- `carry`  in  1  registered ALU carry flag.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `LoadIR`  out  1  IR captures the memory read data.
- `IncPC`  out  1  PC <= PC+1.
- `LoadPC`  out  1  PC <= IR data field (`IR[7:4]`).
- `LoadAcc`  out  1  accumulator load.
- `AccSrc`  out  2  accumulator source: 0 ALU, 1 memory data, 2 immediate `IR[7:4]`.
- `AluOp`  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 SHR. Drives 000 when unused.
- `MemRead`  out  1  memory read request.
- `MemWrite`  out  1  memory write request (data = accumulator).
- `AddrSel`  out  1  memory address source: 0 PC, 1 `IR[7:4]`.
- `halted`  out  1  FSM is in HALT.
- `retired`  out  RETW  count of completed instructions; wraps.

## Operation
ISA:
- 0 NOP
- 1 LDA
- 2 STA
- 3 ADD
- 4 SUB
- 5 AND
- 6 OR
- 7 XOR
- 8 NOT
- 9 LDI
- A JMP
- B JZ
- C JC
- D SHL
- E SHR
- F HLT

All memory and ALU-memory operands are at address `IR[7:4]`.

States: FETCH, DECODE, EXEC, MEM_RD, MEM_WR, HALT. The state is registered; outputs are decoded combinationally from the state, `opcode`, flags and `mem_ready`.

- **FETCH**
  - Asserts `MemRead=1`, `AddrSel=0`.
  - When `mem_ready=1`: asserts `LoadIR=1` and `IncPC=1` in the same cycle, then goes to DECODE.
  - Otherwise holds in FETCH.
- **DECODE**
  - One cycle, no strobes.
  - Dispatch: NOP -> FETCH. LDI, NOT, SHL, SHR, JMP, JZ, JC -> EXEC. LDA, ADD..XOR -> MEM_RD. STA -> MEM_WR. HLT -> HALT.
- **EXEC**
  - One cycle, then FETCH.
  - LDI: `LoadAcc=1`, `AccSrc=2`.
  - NOT, SHL, SHR: `LoadAcc=1`, `AccSrc=0`, `AluOp` = 101, 110 or 111 respectively.
  - JMP: `LoadPC=1`.
  - JZ: `LoadPC=zero`.
  - JC: `LoadPC=carry`.
- **MEM_RD**
  - Asserts `MemRead=1`, `AddrSel=1`, and waits for `mem_ready`.
  - In the ready cycle: `LoadAcc=1`. LDA uses `AccSrc=1`. ADD..XOR use `AccSrc=0` with `AluOp` 000..100.
  - Then goes to FETCH.
- **MEM_WR**
  - Asserts `MemWrite=1`, `AddrSel=1` until `mem_ready`, then goes to FETCH.
- **HALT**
  - `halted=1`, all strobes 0. Exits only via reset.

`retired` increments by 1 on every transition into FETCH from a non-FETCH state, and on entry to HALT. It wraps from 2^RETW-1 to 0.

`IncPC` and `LoadPC` are never asserted in the same cycle.

## Timing
- **Reset:** while `reset=1` all outputs are 0, `retired=0`, and the state is FETCH. The first `MemRead` is asserted in the first cycle after release.
- **Reset mid-operation:** reset asserted mid-instruction (including during a pending memory wait) aborts immediately. No strobe is asserted after the reset edge.
- **Cycles per instruction with `mem_ready` held at 1:**
  - NOP: 2 cycles.
  - EXEC-class instructions: 3 cycles.
  - LDA, ALU-memory and STA: 3 cycles.
  - HLT: 2 cycles to HALT.
- **Wait states:** each wait cycle on `mem_ready` adds exactly one cycle. Request signals (`MemRead`/`MemWrite`/`AddrSel`) stay constant while waiting.
- **`mem_ready` outside FETCH/MEM_RD/MEM_WR** is ignored.
- **Flags:** `zero` and `carry` are sampled combinationally in the EXEC cycle. They must reflect the previous instruction's result.

## Configuration
- **`CU_MEM_HANDSHAKE_EN` defined:** `mem_ready` behaves as above; memory phases may stretch indefinitely.
- **`CU_MEM_HANDSHAKE_EN` not defined:**
  - `mem_ready` is ignored and treated as 1.
  - FETCH, MEM_RD and MEM_WR each last exactly one cycle.
  - The port remains but is unused.

## Test plan
- Reset held 3 cycles, then released, `mem_ready=1` -> all outputs 0 during reset; `MemRead=1`, `AddrSel=0` in cycle 1; `LoadIR=1`, `IncPC=1` same cycle; DECODE in cycle 2.
- Program LDI 5 (0x59), ADD 3 (0x33), STA 4 (0x42), HLT (0x0F), `mem_ready=1` -> strobe sequence matches the per-state table; `halted=1` after 11 cycles; `retired=4`.
- JZ 7 (0x7B) with `zero=1`, then with `zero=0` -> `LoadPC=1` in EXEC only for the first; `IncPC` never coincides with `LoadPC`.
- LDA 2 with `mem_ready` low for 3 cycles in FETCH and 2 cycles in MEM_RD -> instruction takes 8 cycles; request signals stable while waiting; a single `LoadAcc` pulse with `AccSrc=1`.
- `reset` pulsed for 2 ns during a MEM_WR wait -> `MemWrite` drops immediately; the next cycle restarts FETCH; `retired=0`.
- Build without `CU_MEM_HANDSHAKE_EN`, `mem_ready` tied to 0 -> STA completes in 3 cycles; 256 NOPs wrap `retired` to 0.
